// File: rtl/tinyriscv_pkg.sv
// tinyriscv_pkg: shared hold-flag encodings, bus widths and hold-controller state type
package tinyriscv_pkg;
  localparam int InstAddrBusW = 32;
  localparam int HoldFlagBusW = 3;
  typedef logic [InstAddrBusW-1:0] InstAddrBus;
  typedef logic [HoldFlagBusW-1:0] Hold_Flag_Bus;
  localparam Hold_Flag_Bus Hold_None = 3'b000;
  localparam Hold_Flag_Bus Hold_Pc   = 3'b001;
  localparam Hold_Flag_Bus Hold_If   = 3'b010;
  localparam Hold_Flag_Bus Hold_Id   = 3'b011;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED, RESUME} ctrl_state_e;
  function automatic Hold_Flag_Bus hold_max(input Hold_Flag_Bus a, input Hold_Flag_Bus b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: pipeline hold/flush arbiter with debug drain-halt-resume sequencing; stall counter built only when PIPE_HOLD_CTRL_PERF_EN is defined
module pipe_hold_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    jump_flag_i,
  input  logic [InstAddrBusW-1:0] jump_addr_i,
  input  logic                    hold_ex_i,
  input  logic                    hold_rib_i,
  input  logic                    int_assert_i,
  input  logic [InstAddrBusW-1:0] int_addr_i,
  input  logic                    halt_req_i,
  output logic [HoldFlagBusW-1:0] hold_flag_o,
  output logic                    jump_flag_o,
  output logic [InstAddrBusW-1:0] jump_addr_o,
  output logic                    halted_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);
  localparam int DW = DRAIN_CYCLES < 1 ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("pipe_hold_ctrl: DRAIN_CYCLES must be at least 1");
  end
  ctrl_state_e state, state_d;
  logic [DW-1:0] drain_cnt, drain_cnt_d;
  logic int_ok, redirect;
  Hold_Flag_Bus pri_hold, fsm_hold;
  always_comb begin
    int_ok = rst_ni && int_assert_i && state != HALTED;
    redirect = int_ok || (rst_ni && jump_flag_i);
    jump_flag_o = redirect;
    jump_addr_o = int_ok ? int_addr_i : redirect ? jump_addr_i : '0;
    pri_hold = (redirect || hold_ex_i) ? Hold_Id : hold_rib_i ? Hold_Pc : Hold_None;
    fsm_hold = state == HALTED ? Hold_Id : state == DRAIN ? Hold_Pc : Hold_None;
    hold_flag_o = rst_ni ? hold_max(pri_hold, fsm_hold) : Hold_None;
    state_d = state;
    drain_cnt_d = drain_cnt;
    case (state)
      RUN: begin
        state_d = halt_req_i ? DRAIN : RUN;
        drain_cnt_d = '0;
      end
      DRAIN: begin
        state_d = !halt_req_i ? RUN
                : (!redirect && !hold_ex_i && drain_cnt == DRAIN_LAST) ? HALTED : DRAIN;
        drain_cnt_d = (!halt_req_i || redirect || drain_cnt == DRAIN_LAST) ? '0
                    : hold_ex_i ? drain_cnt : drain_cnt + 1'b1;
      end
      HALTED: state_d = halt_req_i ? HALTED : RESUME;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RUN;
      drain_cnt <= '0;
      halted_o <= 1'b0;
    end else begin
      state <= state_d;
      drain_cnt <= drain_cnt_d;
      halted_o <= state_d == HALTED;
    end
  end
`ifdef PIPE_HOLD_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_cnt_o <= '0;
    else if (hold_flag_o != Hold_None && stall_cnt_o != '1)
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb_pipe_hold_ctrl: directed vectors with a cycle-level behavioural model checked every cycle
module tb_pipe_hold_ctrl;
  import tinyriscv_pkg::*;
  localparam int DRAIN = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jump_flag, hold_ex, hold_rib, int_assert, halt_req;
  logic [31:0] jump_addr, int_addr;
  logic [2:0] hold_flag, hold_flag_s;
  logic jf_o, jf_s, halted, halted_s;
  logic [31:0] ja_o, ja_s, stall;
  logic [3:0] stall_s;
  int tests = 0;
  int fails = 0;
  bit m_drain = 0, m_halt = 0, m_resume = 0;
  int m_clean = 0;
  longint m_stall = 0;
  always #5 clk = ~clk;
  pipe_hold_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_ex_i(hold_ex), .hold_rib_i(hold_rib), .int_assert_i(int_assert), .int_addr_i(int_addr),
    .halt_req_i(halt_req), .hold_flag_o(hold_flag), .jump_flag_o(jf_o), .jump_addr_o(ja_o),
    .halted_o(halted), .stall_cnt_o(stall)
  );
  pipe_hold_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_ex_i(hold_ex), .hold_rib_i(hold_rib), .int_assert_i(int_assert), .int_addr_i(int_addr),
    .halt_req_i(halt_req), .hold_flag_o(hold_flag_s), .jump_flag_o(jf_s), .jump_addr_o(ja_s),
    .halted_o(halted_s), .stall_cnt_o(stall_s)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic void expect_comb(output logic ejf, output logic [31:0] eja, output logic [2:0] ehf);
    logic iok;
    logic [2:0] p, f;
    iok = int_assert && !m_halt;
    ejf = iok || jump_flag;
    eja = iok ? int_addr : jump_flag ? jump_addr : 32'h0;
    p = (ejf || hold_ex) ? Hold_Id : hold_rib ? Hold_Pc : Hold_None;
    f = m_halt ? Hold_Id : m_drain ? Hold_Pc : Hold_None;
    ehf = p > f ? p : f;
    if (!rst_n) begin
      ejf = 1'b0;
      eja = 32'h0;
      ehf = Hold_None;
    end
  endfunction
  initial begin : model
    logic mjf;
    logic [31:0] mja;
    logic [2:0] mhf;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_drain = 0; m_halt = 0; m_resume = 0; m_clean = 0; m_stall = 0;
      end else begin
        expect_comb(mjf, mja, mhf);
        if (mhf != Hold_None) m_stall++;
        if (m_resume) m_resume = 0;
        else if (m_halt) begin
          if (!halt_req) begin m_halt = 0; m_resume = 1; end
        end else if (m_drain) begin
          if (!halt_req) m_drain = 0;
          else if (mjf) m_clean = 0;
          else if (!hold_ex) begin
            m_clean++;
            if (m_clean == DRAIN) begin m_drain = 0; m_halt = 1; end
          end
        end else if (halt_req) begin
          m_drain = 1; m_clean = 0;
        end
      end
    end
  end
  initial begin : compare
    logic cjf;
    logic [31:0] cja, e32;
    logic [2:0] chf;
    logic [3:0] e4;
    forever begin
      @(negedge clk);
      expect_comb(cjf, cja, chf);
`ifdef PIPE_HOLD_CTRL_PERF_EN
      e32 = m_stall > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : m_stall[31:0];
      e4 = m_stall > 15 ? 4'hF : m_stall[3:0];
`else
      e32 = 32'h0;
      e4 = 4'h0;
`endif
      chk("cyc_hold_flag", hold_flag, chf);
      chk("cyc_jump_flag", jf_o, cjf);
      chk("cyc_jump_addr", ja_o, cja);
      chk("cyc_halted", halted, m_halt);
      chk("cyc_hold_flag_s", hold_flag_s, chf);
      chk("cyc_jump_flag_s", jf_s, cjf);
      chk("cyc_jump_addr_s", ja_s, cja);
      chk("cyc_halted_s", halted_s, m_halt);
      chk("cyc_stall_cnt", stall, e32);
      chk("cyc_stall_cnt_s", stall_s, e4);
    end
  end
  initial begin
    {jump_flag, hold_ex, hold_rib, int_assert, halt_req} = '0;
    jump_addr = 32'h55;
    int_addr = 32'h0;
    jump_flag = 1'b1;
    #1;
    chk("rst_hold", hold_flag, Hold_None);
    chk("rst_jump_flag", jf_o, 0);
    chk("rst_jump_addr", ja_o, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall, 0);
    step(2);
    rst_n = 1'b1;
    jump_flag = 1'b0;
    step(1);
    jump_flag = 1'b1; jump_addr = 32'h100;
    #1;
    chk("jump_flag", jf_o, 1);
    chk("jump_addr", ja_o, 32'h100);
    chk("jump_hold", hold_flag, Hold_Id);
    step(1);
    int_assert = 1'b1; int_addr = 32'h8;
    #1;
    chk("int_over_jump_flag", jf_o, 1);
    chk("int_over_jump_addr", ja_o, 32'h8);
    step(1);
    {jump_flag, int_assert} = '0;
    hold_rib = 1'b1; hold_ex = 1'b1;
    #1;
    chk("ex_rib_hold", hold_flag, Hold_Id);
    hold_ex = 1'b0;
    #1;
    chk("rib_hold", hold_flag, Hold_Pc);
    chk("rib_no_jump_addr", ja_o, 0);
    step(1);
    hold_rib = 1'b0;
    halt_req = 1'b1;
    #1;
    chk("run_hold", hold_flag, Hold_None);
    for (int i = 0; i < DRAIN; i++) begin
      step(1);
      chk("drain_hold", hold_flag, Hold_Pc);
      chk("drain_halted", halted, 0);
    end
    step(1);
    chk("halted", halted, 1);
    chk("halted_hold", hold_flag, Hold_Id);
    int_assert = 1'b1; int_addr = 32'h40;
    #1;
    chk("halted_int_ignored", jf_o, 0);
    chk("halted_int_hold", hold_flag, Hold_Id);
    int_assert = 1'b0;
    halt_req = 1'b0;
    step(1);
    chk("resume_hold", hold_flag, Hold_None);
    chk("resume_halted", halted, 0);
    halt_req = 1'b1;
    step(1);
    chk("resume_to_run_hold", hold_flag, Hold_None);
    step(1);
    chk("redrain_hold", hold_flag, Hold_Pc);
    step(1);
    jump_flag = 1'b1; jump_addr = 32'h200;
    #1;
    chk("drain_jump_flag", jf_o, 1);
    chk("drain_jump_hold", hold_flag, Hold_Id);
    step(1);
    jump_flag = 1'b0;
    for (int i = 0; i < DRAIN; i++) begin
      chk("restart_not_halted", halted, 0);
      step(1);
    end
    chk("restart_halted", halted, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_halted", halted, 0);
    chk("async_rst_hold", hold_flag, Hold_None);
    step(1);
    halt_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_hold", hold_flag, Hold_None);
    halt_req = 1'b1;
    step(2);
    halt_req = 1'b0;
    #1;
    chk("abort_still_drain", hold_flag, Hold_Pc);
    step(1);
    chk("abort_run", hold_flag, Hold_None);
    halt_req = 1'b1;
    step(1);
    hold_ex = 1'b1;
    step(2);
    hold_ex = 1'b0;
    step(2);
    chk("ex_stall_not_halted", halted, 0);
    step(1);
    chk("ex_stall_halted", halted, 1);
    halt_req = 1'b0;
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    hold_rib = 1'b1;
    step(5);
`ifdef PIPE_HOLD_CTRL_PERF_EN
    chk("perf_five", stall, 5);
`else
    chk("perf_off", stall, 0);
`endif
    step(20);
`ifdef PIPE_HOLD_CTRL_PERF_EN
    chk("perf_sat4", stall_s, 4'hF);
    chk("perf_25", stall, 25);
`else
    chk("perf_off_s", stall_s, 0);
`endif
    hold_rib = 1'b0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
